// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and receiver state encoding for the UART
//               receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode selectors
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Divider values for 115200 baud at common system clocks
    localparam int DIV_RATE_50MHZ  = 434;
    localparam int DIV_RATE_200MHZ = 1736;

    // Receiver FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. Head entry is
//               visible on dout whenever empty=0; dout reads 0 when empty.
//               A push into a full FIFO proceeds only if a pop happens in the
//               same cycle; otherwise it is dropped and flagged on drop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  drop
);
    import uart_pkg::*;

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_COUNT);
    assign w_do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign w_do_push = push & (~full | w_do_pop);
    assign drop      = push & full & ~pop;
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : UART receiver with configurable data/parity/stop format,
//               per-character frame and parity error flags, and a FWFT
//               receive FIFO with sticky overflow indication.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS       = 8,
    parameter int PARITY_MODE     = PARITY_NONE,
    parameter int STOP_BITS       = 1,
    parameter int DIV_CNT_BIT     = 11,
    parameter int DIV_CNT_RATE    = DIV_RATE_200MHZ,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxd,
    input  logic                      rd_en,
    input  logic                      clr_err,
    output logic [DATA_BITS-1:0]      q,
    output logic                      q_frame_err,
    output logic                      q_parity_err,
    output logic                      empty,
    output logic                      full,
    output logic [FIFO_DEPTH_LOG2:0]  count,
    output logic                      overflow,
    output logic                      busy
);

    // Divider reloads to RATE-1 so one full count spans exactly one bit time
    localparam logic [DIV_CNT_BIT-1:0] DIV_FULL  = DIV_CNT_BIT'(DIV_CNT_RATE - 1);
    localparam logic [DIV_CNT_BIT-1:0] DIV_HALF  = DIV_CNT_BIT'(DIV_CNT_RATE / 2 - 1);
    localparam logic [DIV_CNT_BIT-1:0] DIV_ONE   = DIV_CNT_BIT'(1);
    localparam logic [3:0]             LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [3:0]             IDX_ONE   = 4'd1;
    localparam logic                   LAST_STOP = (STOP_BITS == 2);
    localparam logic                   ODD_PAR   = (PARITY_MODE == PARITY_ODD);
    localparam int                     FW        = DATA_BITS + 2;

    rx_state_t              r_state;
    rx_state_t              w_state_nxt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic                   r_rxd_prev;
    logic                   w_rxd_s;
    logic                   w_fall;
    logic [DIV_CNT_BIT-1:0] r_div;
    logic                   w_tick;
    logic [3:0]             r_idx;
    logic                   r_stop_idx;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_push;
    logic [FW-1:0]          r_wdata;
    logic [FW-1:0]          w_dout;
    logic                   w_drop;
    logic                   r_overflow;

    assign w_rxd_s     = r_sync2;
    assign w_fall      = r_rxd_prev & ~w_rxd_s;
    assign w_tick      = (r_div == '0);
    assign w_last_data = (r_idx == LAST_BIT);
    assign w_last_stop = (r_stop_idx == LAST_STOP);
    assign busy        = (r_state != ST_IDLE);

    // Two-flop synchroniser plus edge-detect history, all idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_rxd_prev <= r_sync2;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; every decision happens on a divider expiry cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (w_tick) w_state_nxt = w_rxd_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_tick && w_last_data) begin
                    w_state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_tick) w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (w_tick && w_last_stop) w_state_nxt = w_rxd_s ? ST_IDLE : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (w_rxd_s) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bit timing, character assembly and error capture; the FIFO write is
    // registered so it lands one clock after the final stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= '0;
            r_idx        <= '0;
            r_stop_idx   <= 1'b0;
            r_data       <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_push       <= 1'b0;
            r_wdata      <= '0;
        end else begin
            r_push <= 1'b0;
            if (!w_tick) begin
                r_div <= r_div - DIV_ONE;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) r_div <= DIV_HALF;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_div        <= DIV_FULL;
                        r_idx        <= '0;
                        r_stop_idx   <= 1'b0;
                        r_frame_err  <= 1'b0;
                        r_parity_err <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_div  <= DIV_FULL;
                        r_data <= {w_rxd_s, r_data[DATA_BITS-1:1]};
                        r_idx  <= r_idx + IDX_ONE;
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_div        <= DIV_FULL;
                        r_parity_err <= ((^r_data) ^ w_rxd_s) != ODD_PAR;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_div      <= DIV_FULL;
                        r_stop_idx <= 1'b1;
                        if (!w_rxd_s) r_frame_err <= 1'b1;
                        if (w_last_stop) begin
                            r_push  <= 1'b1;
                            r_wdata <= {r_parity_err, r_frame_err | ~w_rxd_s, r_data};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_err) begin
            r_overflow <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH      (FW),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .din   (r_wdata),
        .pop   (rd_en),
        .dout  (w_dout),
        .empty (empty),
        .full  (full),
        .count (count),
        .drop  (w_drop)
    );

    assign q            = w_dout[DATA_BITS-1:0];
    assign q_frame_err  = w_dout[DATA_BITS];
    assign q_parity_err = w_dout[DATA_BITS+1];
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard bench for uart_rx_fifo. Three receivers (8N1, 8E1,
//               8N2) share a clock; a serial driver feeds each line and a
//               monitor drains the FIFOs against expected entries. A short
//               bit time keeps the run small.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int BIT = 16;

    typedef struct {
        logic [1:0] inst;
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rxd;
    logic [2:0] rd_en;
    logic [2:0] clr_err;
    logic [7:0] q [3];
    logic [2:0] fe, pe, empty, full, ovf, busy;
    logic [4:0] cnt [3];

    exp_t sb[$];
    logic [2:0] drain;
    int n_pass  = 0;
    int n_total = 0;

    always #2.5 clk = ~clk;

    uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .DIV_CNT_BIT(11),
                   .DIV_CNT_RATE(BIT), .FIFO_DEPTH_LOG2(4)) u_8n1 (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .rd_en(rd_en[0]), .clr_err(clr_err[0]),
        .q(q[0]), .q_frame_err(fe[0]), .q_parity_err(pe[0]), .empty(empty[0]),
        .full(full[0]), .count(cnt[0]), .overflow(ovf[0]), .busy(busy[0]));

    uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .DIV_CNT_BIT(11),
                   .DIV_CNT_RATE(BIT), .FIFO_DEPTH_LOG2(4)) u_8e1 (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .rd_en(rd_en[1]), .clr_err(clr_err[1]),
        .q(q[1]), .q_frame_err(fe[1]), .q_parity_err(pe[1]), .empty(empty[1]),
        .full(full[1]), .count(cnt[1]), .overflow(ovf[1]), .busy(busy[1]));

    uart_rx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .DIV_CNT_BIT(11),
                   .DIV_CNT_RATE(BIT), .FIFO_DEPTH_LOG2(4)) u_8n2 (
        .clk(clk), .rst(rst), .rxd(rxd[2]), .rd_en(rd_en[2]), .clr_err(clr_err[2]),
        .q(q[2]), .q_frame_err(fe[2]), .q_parity_err(pe[2]), .empty(empty[2]),
        .full(full[2]), .count(cnt[2]), .overflow(ovf[2]), .busy(busy[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_char(input logic [1:0] k, input logic [7:0] d,
                               input logic f, input logic p);
        exp_t e;
        e.inst = k; e.d = d; e.fe = f; e.pe = p;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [1:0] k, input logic v, input int nbits);
        rxd[k] = v;
        repeat (nbits * BIT) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] k, input logic [7:0] d, input bit has_par,
                        input logic par, input bit two_stop, input logic s2);
        drive(k, 1'b0, 1);
        for (int i = 0; i < 8; i++) drive(k, d[3'(i)], 1);
        if (has_par) drive(k, par, 1);
        drive(k, 1'b1, 1);
        if (two_stop) drive(k, s2, 1);
    endtask

    task automatic wait_empty(input logic [1:0] k, input string name);
        for (int c = 0; c < 200 && !empty[k]; c++) @(negedge clk);
        check(name, 32'(empty[k]), 32'd1);
    endtask

    // Monitor: pops any presented head entry of a drained instance and scores it
    initial begin
        rd_en = '0;
        forever begin
            @(negedge clk);
            rd_en = '0;
            for (int i = 0; i < 3; i++) begin
                logic [1:0] k;
                k = 2'(i);
                if (drain[k] && !empty[k] && !rst) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_entry inst%0d: got q=0x%0h, expected none", k, q[k]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sb_inst", 32'(k), 32'(e.inst));
                        check("sb_data", 32'(q[k]), 32'(e.d));
                        check("sb_frame_err", 32'(fe[k]), 32'(e.fe));
                        check("sb_parity_err", 32'(pe[k]), 32'(e.pe));
                    end
                    rd_en[k] = 1'b1;
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rxd = 3'b111; clr_err = '0; drain = '0; rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state of all three receivers
        for (int i = 0; i < 3; i++) begin
            logic [1:0] k;
            k = 2'(i);
            check("rst_empty", 32'(empty[k]), 32'd1);
            check("rst_full", 32'(full[k]), 32'd0);
            check("rst_count", 32'(cnt[k]), 32'd0);
            check("rst_overflow", 32'(ovf[k]), 32'd0);
            check("rst_busy", 32'(busy[k]), 32'd0);
            check("rst_q", 32'({q[k], fe[k], pe[k]}), 32'd0);
        end

        // 8N1 ordered reception, FIFO holds three before draining
        expect_char(2'd0, 8'h55, 1'b0, 1'b0);
        expect_char(2'd0, 8'hA3, 1'b0, 1'b0);
        expect_char(2'd0, 8'h00, 1'b0, 1'b0);
        send(2'd0, 8'h55, 0, 1'b0, 0, 1'b1);
        check("t1_count_first", 32'(cnt[0]), 32'd1);
        drive(2'd0, 1'b1, 1);
        send(2'd0, 8'hA3, 0, 1'b0, 0, 1'b1);
        drive(2'd0, 1'b1, 1);
        send(2'd0, 8'h00, 0, 1'b0, 0, 1'b1);
        drive(2'd0, 1'b1, 1);
        check("t1_count3", 32'(cnt[0]), 32'd3);
        check("t1_head", 32'(q[0]), 32'h55);
        drain[0] = 1'b1;
        wait_empty(2'd0, "t1_drained");

        // 8E1: 0x07 has odd weight, so even parity bit 1 is correct, 0 is an error
        drain[1] = 1'b1;
        expect_char(2'd1, 8'h07, 1'b0, 1'b0);
        send(2'd1, 8'h07, 1, 1'b1, 0, 1'b1);
        drive(2'd1, 1'b1, 1);
        expect_char(2'd1, 8'h07, 1'b0, 1'b1);
        send(2'd1, 8'h07, 1, 1'b0, 0, 1'b1);
        drive(2'd1, 1'b1, 1);
        wait_empty(2'd1, "t2_drained");

        // 8N2: bad second stop bit then a 20-bit break, then a clean character
        expect_char(2'd2, 8'h3C, 1'b1, 1'b0);
        send(2'd2, 8'h3C, 0, 1'b0, 1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            repeat (4 * BIT) @(negedge clk);
            check("t3_busy_break", 32'(busy[2]), 32'd1);
        end
        check("t3_count_break", 32'(cnt[2]), 32'd1);
        drive(2'd2, 1'b1, 2);
        check("t3_idle_after_break", 32'(busy[2]), 32'd0);
        expect_char(2'd2, 8'h81, 1'b0, 1'b0);
        send(2'd2, 8'h81, 0, 1'b0, 1, 1'b1);
        drive(2'd2, 1'b1, 1);
        check("t3_count2", 32'(cnt[2]), 32'd2);
        drain[2] = 1'b1;
        wait_empty(2'd2, "t3_drained");

        // Short low glitch on idle line is a false start
        rxd[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_busy_glitch", 32'(busy[0]), 32'd1);
        rxd[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_busy_clear", 32'(busy[0]), 32'd0);
        check("t4_no_write", 32'(empty[0]), 32'd1);

        // Overflow: 17 characters with no reads, 17th dropped
        drain[0] = 1'b0;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] v;
            v = 8'(i * 37 + 5);
            if (i < 16) expect_char(2'd0, v, 1'b0, 1'b0);
            send(2'd0, v, 0, 1'b0, 0, 1'b1);
        end
        drive(2'd0, 1'b1, 1);
        check("t5_full", 32'(full[0]), 32'd1);
        check("t5_count16", 32'(cnt[0]), 32'd16);
        check("t5_overflow", 32'(ovf[0]), 32'd1);
        check("t5_head_first", 32'(q[0]), 32'h05);
        clr_err[0] = 1'b1;
        @(negedge clk);
        clr_err[0] = 1'b0;
        check("t5_overflow_cleared", 32'(ovf[0]), 32'd0);
        drain[0] = 1'b1;
        wait_empty(2'd0, "t5_drained");
        check("t5_count0", 32'(cnt[0]), 32'd0);

        // Reset while data bit 5 (a 1) of 0xF0 is on the line
        fork
            send(2'd0, 8'hF0, 0, 1'b0, 0, 1'b1);
        join_none
        repeat (6 * BIT + 4) @(negedge clk);
        check("t6_busy_mid_data", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_empty_after_rst", 32'(empty[0]), 32'd1);
        check("t6_busy_after_rst", 32'(busy[0]), 32'd0);
        wait fork;
        drive(2'd0, 1'b1, 1);
        check("t6_no_write_aborted", 32'(empty[0]), 32'd1);
        expect_char(2'd0, 8'h12, 1'b0, 1'b0);
        send(2'd0, 8'h12, 0, 1'b0, 0, 1'b1);
        drive(2'd0, 1'b1, 1);
        wait_empty(2'd0, "t6_drained");

        check("sb_all_consumed", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver.
- Decodes an asynchronous serial line of configurable character format: data bits, parity mode and stop bits.
- Flags framing and parity errors per character.
- Buffers received characters, with their error flags, in an on-chip first-word-fall-through FIFO, so a slow consumer (command decoder, register bus bridge) can drain it at its own pace.
- Sits between the board RXD pin and the control-path logic on the 200 MHz system clock.

Parameters:
- DATA_BITS, 8: data bits per character, legal 5..9; sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- DIV_CNT_BIT, 11: width of the baud divider counter.
- DIV_CNT_RATE, 1736: clk cycles per bit; 1736 at 200 MHz gives 115200 baud. Minimum 8.
- FIFO_DEPTH_LOG2, 4: FIFO depth is 2**FIFO_DEPTH_LOG2 entries (16).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rxd  in  1  asynchronous serial input, idle high
- rd_en  in  1  pop head entry; ignored when empty
- clr_err  in  1  clears sticky overflow
- q  out  DATA_BITS  head data, valid while empty=0
- q_frame_err  out  1  head entry stop-bit error
- q_parity_err  out  1  head entry parity error; always 0 when PARITY_MODE=0
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- count  out  FIFO_DEPTH_LOG2+1  number of entries held
- overflow  out  1  sticky: a character was dropped
- busy  out  1  receiver not in IDLE

Behaviour:
- Reset values:
  - State IDLE; FIFO pointers and count cleared.
  - q=0, q_frame_err=0, q_parity_err=0, empty=1, full=0, count=0, overflow=0, busy=0.
  - Synchroniser flops preset to 1.
- Reset mid-frame aborts the character; nothing is written.
- Input path: 2-flop synchroniser on rxd. All decisions use the synchronised value rxd_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - A 1->0 transition of rxd_s loads the divider with DIV_CNT_RATE/2 and enters START.
  - busy=1 in every state except IDLE.
- START: at divider expiry, sample rxd_s.
  - If 1: false start; return to IDLE, nothing written.
  - If 0: reload DIV_CNT_RATE, clear bit index, enter DATA.
- DATA:
  - At each expiry, shift rxd_s into bit[index], LSB first.
  - After DATA_BITS samples, enter PARITY if PARITY_MODE!=0, else STOP.
- PARITY: one sample. parity_err = (XOR of data bits ^ sample) != (PARITY_MODE==2).
- STOP:
  - STOP_BITS samples; frame_err=1 if any stop sample is 0.
  - On the final stop sample, write {parity_err, frame_err, data} into the FIFO.
  - Next state is IDLE if that sample was 1, else WAIT_IDLE.
- WAIT_IDLE (break or low line): stay until rxd_s==1, then IDLE. No further characters are written during a break.
- Receive latency: empty deasserts (count increments) on the clk edge after the final stop-sample edge. q is valid in that same cycle (FWFT).
- FIFO rules:
  - rd_en while empty=0 pops; the next entry appears on q the following cycle.
  - rd_en while empty=1 is ignored.
  - Write while full and rd_en=0: character dropped, overflow set to 1 and held.
  - Write while full and rd_en=1 in the same cycle: both proceed; count unchanged, overflow not set.
  - Write and read when count=1: count stays 1; q shows the new entry next cycle.
  - Pointers wrap modulo depth; count saturates at 2**FIFO_DEPTH_LOG2 and full=1 there.
- overflow clears on clr_err=1. If clr_err and a dropping write occur in the same cycle, set wins.
- Divider: counts down to 0. The expiry cycle is the sample cycle, and the divider reloads on that same edge.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state encoding.
  - Default DIV_CNT_RATE values for 50 MHz (434) and 200 MHz (1736).
- One sub-module: sync_fifo_fwft, parameters WIDTH and DEPTH_LOG2. It provides push, pop, dout, empty, full, count, and drop, where drop = push & full & ~pop. The receiver FSM stays in uart_rx_fifo.

Test Plan:
- Common setup: DIV_CNT_RATE=1736, 8N1. Bench transmitter at 115200 baud.
- Send 0x55, 0xA3, 0x00 -> q shows 0x55, 0xA3, 0x00 in order with both error flags 0. count reaches 3; empty falls 1 clk after each stop-bit mid-sample.
- Reconfigure 8E1. Send 0x07 with parity bit 1, then 0x07 with parity bit 0 -> first entry q_parity_err=0. Second entry q_parity_err=1 with q=0x07.
- Reconfigure 8N2. Send 0x3C with second stop bit 0, then hold rxd low 20 bit times, then send 0x81 -> entries are 0x3C with frame_err=1, then 0x81 with frame_err=0. Exactly 2 entries; busy stays 1 during the break.
- Drive a 400-cycle low glitch on idle rxd -> no write; busy returns to 0 after the start-bit mid-sample.
- Send 17 characters with rd_en=0 -> full=1, count=16, overflow=1, head is still character 1. Then pulse clr_err -> overflow=0. Then pop 16 -> characters 1..16 in order, empty=1.
- Assert rst mid-DATA of 0xF0 -> FIFO empty and busy=0. The next character 0x12 is received correctly.
